// File: rtl/uart_pkg.sv
// Shared UART transmit types: FSM state encoding, frame geometry and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO in front of the UART transmitter; wrap-around pointers with an extra lap bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with different lap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB-first, even parity, stop; tx is a registered decode of the state.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry byte FIFO in front of the FSM.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       send,
  output logic       ready,
  output logic       busy,
  output logic       tx,
  output logic [2:0] dbg_state
);

  localparam int                TICK_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  uart_state_t state, state_next;
  logic [TICK_W-1:0] tick, tick_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shift, shift_next;
  logic              parity_q, parity_next;
  logic              tx_next;
  logic              tick_done;
  logic              start_frame;
  logic [7:0]        load_data;

`ifdef UART_TX_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;

  assign ready       = !fifo_full;
  assign start_frame = (state == IDLE) && !fifo_empty;
  assign load_data   = fifo_rdata;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (send && ready),
    .wdata (data),
    .pop   (start_frame),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  assign ready       = (state == IDLE) && !rst;
  assign start_frame = send && ready;
  assign load_data   = data;
`endif

  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign tick_done = (tick == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      parity_q <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      tick     <= tick_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      parity_q <= parity_next;
      tx       <= tx_next;
    end
  end

  always_comb begin
    state_next  = state;
    tick_next   = tick;
    bit_next    = bit_idx;
    shift_next  = shift;
    parity_next = parity_q;
    tx_next     = 1'b1;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (start_frame) begin
          shift_next  = load_data;
          parity_next = uart_parity(load_data);
          tick_next   = '0;
          bit_next    = '0;
          state_next  = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (tick_done) begin
          tick_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          tick_next = tick + 1'b1;
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (tick_done) begin
          tick_next  = '0;
          shift_next = shift >> 1;
          if (bit_idx == BIT_LAST) begin
            bit_next   = '0;
            state_next = PARITY;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end else begin
          tick_next = tick + 1'b1;
        end
      end
      PARITY: begin
        tx_next = parity_q;
        if (tick_done) begin
          tick_next  = '0;
          state_next = STOP;
        end else begin
          tick_next = tick + 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (tick_done) begin
          tick_next  = '0;
          state_next = IDLE;
        end else begin
          tick_next = tick + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tick_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a CLKS_PER_BIT=1 and a CLKS_PER_BIT=4 instance, frame-decoding monitors with expected queues.
module tb_uart_transmitter;

`ifdef UART_TX_FIFO_EN
  localparam int FIFO_ON = 1;
`else
  localparam int FIFO_ON = 0;
`endif
  localparam int LAT = 1 + FIFO_ON;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data1, data4;
  logic       send1, send4;
  logic       ready1, ready4;
  logic       busy1, busy4;
  logic       tx1, tx4;
  logic [2:0] st1, st4;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q4[$];

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .data(data1), .send(send1),
    .ready(ready1), .busy(busy1), .tx(tx1), .dbg_state(st1)
  );

  uart_transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .data(data4), .send(send4),
    .ready(ready4), .busy(busy4), .tx(tx4), .dbg_state(st4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int which);
    return (which == 0) ? tx1 : tx4;
  endfunction

  // Decodes one frame per start bit, checking each bit holds for cpb clocks.
  task automatic monitor(input int which, input int cpb);
    logic [10:0] fr;
    logic [10:0] exp_fr;
    logic [7:0]  exp_b;
    logic        held;
    logic        aborted;
    forever begin
      @(negedge clk);
      if (get_tx(which) === 1'b0 && rst === 1'b0) begin
        fr      = '0;
        held    = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < 11 && !aborted; b++) begin
          for (int k = 0; k < cpb && !aborted; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (rst) aborted = 1'b1;
            else if (k == 0) fr[b] = get_tx(which);
            else if (get_tx(which) !== fr[b]) held = 1'b0;
          end
        end
        if (!aborted) begin
          if ((which == 0 && exp_q1.size() == 0) || (which == 1 && exp_q4.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame dut=%0d actual=%h required=none", which, fr);
          end else begin
            exp_b  = (which == 0) ? exp_q1.pop_front() : exp_q4.pop_front();
            exp_fr = {1'b1, ^exp_b, exp_b, 1'b0};
            check($sformatf("frame_dut%0d_%h", which, exp_b), 32'(fr), 32'(exp_fr));
            check($sformatf("bit_hold_dut%0d", which), 32'(held), 32'd1);
            @(negedge clk);
            check($sformatf("idle_gap_dut%0d", which), 32'(get_tx(which)), 32'd1);
          end
        end
      end
    end
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic exp_ready, input string name);
    @(posedge clk);
    #1;
    if (which == 0) begin data1 = b; send1 = 1'b1; end
    else            begin data4 = b; send4 = 1'b1; end
    @(negedge clk);
    check(name, 32'(which == 0 ? ready1 : ready4), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (which == 0) begin send1 = 1'b0; data1 = ~b; end
    else            begin send4 = 1'b0; data4 = ~b; end
  endtask

  initial begin
    int busy_cnt;
    int rdy_low;
    rst   = 1'b1;
    send1 = 1'b0; send4 = 1'b0;
    data1 = 8'h00; data4 = 8'h00;
    fork
      monitor(0, 1);
      monitor(1, 4);
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx1", 32'(tx1), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_ready1", 32'(ready1), 32'(FIFO_ON));
    check("rst_state1", 32'(st1), 32'd0);
    check("rst_tx4", 32'(tx4), 32'd1);
    check("rst_busy4", 32'(busy4), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready1_after_rst", 32'(ready1), 32'd1);
    check("ready4_after_rst", 32'(ready4), 32'd1);

    // 0xA5: latency to start bit
    exp_q1.push_back(8'hA5);
    send_byte(0, 8'hA5, 1'b1, "ready_a5");
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check("lat_still_idle", 32'(tx1), 32'd1);
    end
    @(negedge clk);
    check("lat_start_bit", 32'(tx1), 32'd0);
    repeat (20) @(negedge clk);

    // 0x01: parity 1, busy for 11 clocks
    exp_q1.push_back(8'h01);
    send_byte(0, 8'h01, 1'b1, "ready_01");
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy1) busy_cnt++;
    end
    check("busy_cycles_cpb1", 32'(busy_cnt), 32'd11);

    // 0x00: parity 0
    exp_q1.push_back(8'h00);
    send_byte(0, 8'h00, 1'b1, "ready_00");
    repeat (20) @(negedge clk);

    // Second send while busy
    exp_q1.push_back(8'hA5);
    send_byte(0, 8'hA5, 1'b1, "ready_a5_again");
    repeat (3) @(posedge clk);
`ifdef UART_TX_FIFO_EN
    exp_q1.push_back(8'h55);
`endif
    send_byte(0, 8'h55, 1'(FIFO_ON), "ready_while_busy");
    repeat (40) @(negedge clk);
    check("state1_idle", 32'(st1), 32'd0);

    // Reset during DATA bit 3
    send_byte(0, 8'hC3, 1'b1, "ready_c3");
    repeat (LAT + 3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("state1_data_before_rst", 32'(st1), 32'd2);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_tx1", 32'(tx1), 32'd1);
    check("abort_busy1", 32'(busy1), 32'd0);
    check("abort_ready1", 32'(ready1), 32'd1);
    exp_q1.push_back(8'h81);
    send_byte(0, 8'h81, 1'b1, "ready_81");
    repeat (20) @(negedge clk);

    // CLKS_PER_BIT=4, 0x3C
    exp_q4.push_back(8'h3C);
    send_byte(1, 8'h3C, 1'b1, "ready_3c");
    busy_cnt = 0;
    rdy_low  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy4)   busy_cnt++;
      if (!ready4) rdy_low++;
    end
    check("busy_cycles_cpb4", 32'(busy_cnt), 32'd44);
    check("ready_low_cpb4", 32'(rdy_low), FIFO_ON ? 32'd0 : 32'd44);

`ifdef UART_TX_FIFO_EN
    // Fill the FIFO while a frame is in flight; the fifth byte is refused
    exp_q1.push_back(8'h11);
    send_byte(0, 8'h11, 1'b1, "fifo_ready_first");
    @(posedge clk);
    exp_q1.push_back(8'h22);
    send_byte(0, 8'h22, 1'b1, "fifo_ready_1");
    exp_q1.push_back(8'h33);
    send_byte(0, 8'h33, 1'b1, "fifo_ready_2");
    exp_q1.push_back(8'h44);
    send_byte(0, 8'h44, 1'b1, "fifo_ready_3");
    exp_q1.push_back(8'h55);
    send_byte(0, 8'h55, 1'b1, "fifo_ready_4");
    send_byte(0, 8'h66, 1'b0, "fifo_ready_full");
    repeat (80) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    check("q4_drained", 32'(exp_q4.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
